// File: rtl/mbx_nfifo_pkg.sv
`default_nettype none
// =============================================================================
// mbx_nfifo_pkg : register map, AHB encodings and phase type for mbx_nfifo
// Rev 1.0
// =============================================================================
package mbx_nfifo_pkg;

  localparam logic [1:0] C_REG_CTRL   = 2'd0;
  localparam logic [1:0] C_REG_TXDATA = 2'd1;
  localparam logic [1:0] C_REG_RXDATA = 2'd2;
  localparam logic [1:0] C_REG_STATUS = 2'd3;

  localparam int C_CTRL_INT_EN = 0;
  localparam int C_ST_EMPTY    = 8;
  localparam int C_ST_FULL     = 9;
  localparam int C_ST_DFULL    = 10;
  localparam int C_ST_OVF      = 16;

  localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] C_HRESP_OKAY    = 2'b00;
  localparam logic [1:0] C_HRESP_ERROR   = 2'b01;

  localparam logic [2:0] C_HSIZE_BYTE = 3'b000;
  localparam logic [2:0] C_HSIZE_HALF = 3'b001;
  localparam logic [2:0] C_HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_DATA = 2'd1,
    PH_ERR1 = 2'd2,
    PH_ERR2 = 2'd3
  } phase_t;

  // Narrow TXDATA writes take the low byte lanes, zero-extended.
  function automatic logic [31:0] lane_extend(input logic [2:0] size, input logic [31:0] data);
    case (size)
      C_HSIZE_BYTE: return {24'd0, data[7:0]};
      C_HSIZE_HALF: return {16'd0, data[15:0]};
      default:      return data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbx_fifo.sv
`default_nettype none
// =============================================================================
// mbx_fifo : DEPTH x 32 inbox FIFO with occupancy count
// Rev 1.0
// =============================================================================
module mbx_fifo
  import mbx_nfifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_CNT = DEPTH[AW:0];

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == C_FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/mbx_nfifo.sv
`default_nettype none
// =============================================================================
// mbx_nfifo : N-core AHB-lite mailbox, one slave port and one inbox per core
// Rev 1.0
// =============================================================================
module mbx_nfifo
  import mbx_nfifo_pkg::*;
#(
  parameter int          N_CORE    = 2,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                     hclk,
  input  logic                     hrst_b,
  input  logic [N_CORE-1:0]        hsel,
  input  logic [N_CORE-1:0][31:0]  haddr,
  input  logic [N_CORE-1:0][1:0]   htrans,
  input  logic [N_CORE-1:0]        hwrite,
  input  logic [N_CORE-1:0][2:0]   hsize,
  input  logic [N_CORE-1:0][31:0]  hwdata,
  output logic [N_CORE-1:0][31:0]  hrdata,
  output logic [N_CORE-1:0]        hready,
  output logic [N_CORE-1:0][1:0]   hresp,
  output logic [N_CORE-1:0]        rx_intr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_CORE-1:0]          w_tx_req, w_grant, w_drop, w_push, w_pop, w_full, w_empty;
  logic [N_CORE-1:0][2:0]     w_tx_dest;
  logic [N_CORE-1:0][31:0]    w_tx_data, w_push_data, w_fifo_rdata;
  logic [N_CORE-1:0][CW-1:0]  w_count;

  // Per inbox, the lowest-indexed requesting port wins; losers stall and retry.
  always_comb begin : arbiter
    logic found;
    found       = 1'b0;
    w_grant     = '0;
    w_drop      = '0;
    w_push      = '0;
    w_push_data = '0;
    for (int j = 0; j < N_CORE; j++) begin
      found = 1'b0;
      for (int i = 0; i < N_CORE; i++) begin
        if (!found && w_tx_req[i] && (32'(w_tx_dest[i]) == j)) begin
          found          = 1'b1;
          w_grant[i]     = 1'b1;
          w_drop[i]      = w_full[j];
          w_push[j]      = ~w_full[j];
          w_push_data[j] = w_tx_data[i];
        end
      end
    end
  end

  for (genvar p = 0; p < N_CORE; p++) begin : g_port
    phase_t      r_phase, w_phase_nxt;
    logic        r_wr, r_int_en, r_ovf, r_intr;
    logic [1:0]  r_reg, w_reg;
    logic [2:0]  r_size, r_dest, r_ctrl_dest;
    logic [6:0]  r_thr, w_thr_eff;
    logic [31:0] r_rdata, w_rd_val, w_status, w_ctrl;
    logic        w_ready, w_sel, w_addr_ok, w_dest_ok, w_err, w_acc, w_dest_full, w_data_wr;

    mbx_fifo #(.DEPTH(DEPTH)) u_inbox (
      .clk   (hclk),
      .rst_n (hrst_b),
      .push  (w_push[p]),
      .wdata (w_push_data[p]),
      .pop   (w_pop[p]),
      .rdata (w_fifo_rdata[p]),
      .count (w_count[p]),
      .full  (w_full[p]),
      .empty (w_empty[p])
    );

    assign w_tx_req[p]  = (r_phase == PH_DATA) & r_wr & (r_reg == C_REG_TXDATA);
    assign w_tx_dest[p] = r_dest;
    assign w_tx_data[p] = lane_extend(r_size, hwdata[p]);
    assign w_data_wr    = (r_phase == PH_DATA) & r_wr;

    assign w_ready    = (r_phase == PH_ERR1) ? 1'b0 : ~(w_tx_req[p] & ~w_grant[p]);
    assign hready[p]  = w_ready;
    assign hresp[p]   = (r_phase == PH_ERR1 || r_phase == PH_ERR2) ? C_HRESP_ERROR : C_HRESP_OKAY;
    assign hrdata[p]  = r_rdata;
    assign rx_intr[p] = r_intr;

    assign w_reg     = haddr[p][3:2];
    assign w_sel     = hsel[p] & w_ready;
    assign w_addr_ok = (haddr[p][31:4] == BASE_ADDR[31:4]) && (haddr[p][1:0] == 2'b00);
    assign w_dest_ok = (32'(r_ctrl_dest) < N_CORE) && (32'(r_ctrl_dest) != p);

    always_comb begin
      w_err = 1'b0;
      if (w_sel) begin
        if (htrans[p] == C_HTRANS_SEQ) begin
          w_err = 1'b1;
        end else if (htrans[p] == C_HTRANS_NONSEQ) begin
          w_err = !w_addr_ok || (hsize[p] > C_HSIZE_WORD) ||
                  (hwrite[p] && (w_reg == C_REG_TXDATA) && !w_dest_ok);
        end
      end
    end

    assign w_acc    = w_sel & (htrans[p] == C_HTRANS_NONSEQ) & ~w_err;
    assign w_pop[p] = w_acc & ~hwrite[p] & (w_reg == C_REG_RXDATA) & ~w_empty[p];

    always_comb begin
      w_phase_nxt = r_phase;
      if (r_phase == PH_ERR1)
        w_phase_nxt = PH_ERR2;
      else if (w_ready)
        w_phase_nxt = w_err ? PH_ERR1 : (w_acc ? PH_DATA : PH_IDLE);
    end

    always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) r_phase <= PH_IDLE;
      else         r_phase <= w_phase_nxt;
    end

    always_comb begin
      w_dest_full = 1'b0;
      for (int j = 0; j < N_CORE; j++)
        if (32'(r_ctrl_dest) == j) w_dest_full = w_full[j];
    end

    always_comb begin
      w_status             = '0;
      w_status[6:0]        = 7'(w_count[p]);
      w_status[C_ST_EMPTY] = w_empty[p];
      w_status[C_ST_FULL]  = w_full[p];
      w_status[C_ST_DFULL] = w_dest_full;
      w_status[C_ST_OVF]   = r_ovf;
    end

    assign w_ctrl = {9'd0, r_thr, 5'd0, r_ctrl_dest, 7'd0, r_int_en};

    always_comb begin
      w_rd_val = '0;
      if (w_acc && !hwrite[p]) begin
        case (w_reg)
          C_REG_CTRL:   w_rd_val = w_ctrl;
          C_REG_RXDATA: w_rd_val = w_empty[p] ? 32'd0 : w_fifo_rdata[p];
          C_REG_STATUS: w_rd_val = w_status;
          default:      w_rd_val = '0;
        endcase
      end
    end

    assign w_thr_eff = (r_thr == 7'd0) ? 7'd1 : r_thr;

    always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
        r_wr        <= 1'b0;
        r_reg       <= '0;
        r_size      <= '0;
        r_dest      <= '0;
        r_int_en    <= 1'b0;
        r_ctrl_dest <= '0;
        r_thr       <= '0;
        r_ovf       <= 1'b0;
        r_intr      <= 1'b0;
        r_rdata     <= '0;
      end else begin
        if (w_ready) begin
          r_rdata <= w_rd_val;
          if (w_acc) begin
            r_wr   <= hwrite[p];
            r_reg  <= w_reg;
            r_size <= hsize[p];
            r_dest <= r_ctrl_dest;
          end
        end
        if (w_data_wr && (r_reg == C_REG_CTRL)) begin
          r_int_en    <= hwdata[p][C_CTRL_INT_EN];
          r_ctrl_dest <= hwdata[p][10:8];
          r_thr       <= hwdata[p][22:16];
        end
        if (w_drop[p])
          r_ovf <= 1'b1;
        else if (w_data_wr && (r_reg == C_REG_STATUS) && hwdata[p][C_ST_OVF])
          r_ovf <= 1'b0;
        r_intr <= r_int_en & (7'(w_count[p]) >= w_thr_eff);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mbx_nfifo.sv
`default_nettype none
// =============================================================================
// tb_mbx_nfifo : directed self-checking bench for mbx_nfifo (N_CORE=3, DEPTH=4)
// Rev 1.0
// =============================================================================
module tb_mbx_nfifo;

  localparam int          NC     = 3;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_TX   = BASE + 32'h4;
  localparam logic [31:0] A_RX   = BASE + 32'h8;
  localparam logic [31:0] A_ST   = BASE + 32'hC;

  logic                 hclk   = 1'b0;
  logic                 hrst_b = 1'b0;
  logic [NC-1:0]        hsel   = '0;
  logic [NC-1:0][31:0]  haddr  = '0;
  logic [NC-1:0][1:0]   htrans = '0;
  logic [NC-1:0]        hwrite = '0;
  logic [NC-1:0][2:0]   hsize  = '0;
  logic [NC-1:0][31:0]  hwdata = '0;
  logic [NC-1:0][31:0]  hrdata;
  logic [NC-1:0]        hready;
  logic [NC-1:0][1:0]   hresp;
  logic [NC-1:0]        rx_intr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  mbx_nfifo #(.N_CORE(NC), .DEPTH(4), .BASE_ADDR(BASE)) dut (
    .hclk    (hclk),
    .hrst_b  (hrst_b),
    .hsel    (hsel),
    .haddr   (haddr),
    .htrans  (htrans),
    .hwrite  (hwrite),
    .hsize   (hsize),
    .hwdata  (hwdata),
    .hrdata  (hrdata),
    .hready  (hready),
    .hresp   (hresp),
    .rx_intr (rx_intr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One AHB transfer on port p; called #1 after a rising edge, returns likewise.
  task automatic xfer(input int p, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] size, input logic [1:0] trans,
                      output logic [31:0] rd, output logic [1:0] resp,
                      output logic [1:0] resp_end, output int waits);
    int guard;
    guard     = 0;
    hsel[p]   = 1'b1;
    haddr[p]  = addr;
    htrans[p] = trans;
    hwrite[p] = wr;
    hsize[p]  = size;
    while (!hready[p] && guard < 20) begin
      @(posedge hclk); #1;
      guard++;
    end
    if (guard >= 20) check("addr_phase_timeout", 32'(guard), 32'd0);
    @(posedge hclk); #1;
    hsel[p]   = 1'b0;
    htrans[p] = 2'b00;
    hwrite[p] = 1'b0;
    hwdata[p] = wd;
    rd    = hrdata[p];
    resp  = hresp[p];
    waits = 0;
    while (!hready[p] && waits < 20) begin
      @(posedge hclk); #1;
      waits++;
    end
    resp_end = hresp[p];
    @(posedge hclk); #1;
  endtask

  task automatic do_write(input int p, input logic [31:0] addr, input logic [31:0] wd,
                          input string tag);
    logic [31:0] rd; logic [1:0] r1, r2; int w;
    xfer(p, 1'b1, addr, wd, 3'b010, 2'b10, rd, r1, r2, w);
    check({tag, "_resp"}, 32'(r1), 32'd0);
  endtask

  task automatic do_read(input int p, input logic [31:0] addr, input logic [31:0] exp,
                         input string tag);
    logic [31:0] rd; logic [1:0] r1, r2; int w;
    xfer(p, 1'b0, addr, 32'd0, 3'b010, 2'b10, rd, r1, r2, w);
    check(tag, rd, exp);
  endtask

  task automatic do_err(input int p, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [1:0] trans, input string tag);
    logic [31:0] rd; logic [1:0] r1, r2; int w;
    xfer(p, wr, addr, 32'h0000_00DD, size, trans, rd, r1, r2, w);
    check({tag, "_resp1"}, 32'(r1), 32'd1);
    check({tag, "_waits"}, 32'(w), 32'd1);
    check({tag, "_resp2"}, 32'(r2), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    check("rst_hready", 32'(hready), 32'h7);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_intr", 32'(rx_intr), 32'h0);
    for (int i = 0; i < NC; i++) check("rst_hrdata", hrdata[i], 32'h0);
    hrst_b = 1'b1;
    @(posedge hclk); #1;

    // Basic ordering and full/overflow handling, port0 -> inbox1
    do_write(0, A_CTRL, 32'h0000_0100, "ctrl0");
    do_read(1, A_ST, 32'h0000_0100, "st1_empty");
    do_write(0, A_TX, 32'h0000_00A1, "tx_a1");
    do_write(0, A_TX, 32'h0000_00A2, "tx_a2");
    do_write(0, A_TX, 32'h0000_00A3, "tx_a3");
    do_write(0, A_TX, 32'h0000_00A4, "tx_a4");
    do_read(1, A_ST, 32'h0000_0204, "st1_full");
    do_read(0, A_ST, 32'h0000_0500, "st0_dest_full");
    do_write(0, A_TX, 32'h0000_00A5, "tx_a5_drop");
    do_read(0, A_ST, 32'h0001_0500, "st0_ovf");
    do_write(0, A_ST, 32'h0001_0000, "ovf_clr");
    do_read(0, A_ST, 32'h0000_0500, "st0_ovf_cleared");
    do_read(1, A_RX, 32'h0000_00A1, "rx_a1");
    do_read(1, A_RX, 32'h0000_00A2, "rx_a2");
    do_read(1, A_RX, 32'h0000_00A3, "rx_a3");
    do_read(1, A_RX, 32'h0000_00A4, "rx_a4");
    do_read(1, A_ST, 32'h0000_0100, "st1_drained");
    do_read(1, A_RX, 32'h0000_0000, "rx_empty_pop");

    // Threshold interrupt on port1
    do_write(1, A_CTRL, 32'h0002_0001, "ctrl1_int");
    do_read(1, A_CTRL, 32'h0002_0001, "ctrl1_readback");
    do_write(0, A_TX, 32'h0000_00B1, "tx_b1");
    check("intr_after_push1", 32'(rx_intr[1]), 32'd0);
    @(posedge hclk); #1;
    check("intr_count1", 32'(rx_intr[1]), 32'd0);
    do_write(0, A_TX, 32'h0000_00B2, "tx_b2");
    check("intr_same_cycle", 32'(rx_intr[1]), 32'd0);
    @(posedge hclk); #1;
    check("intr_rise", 32'(rx_intr[1]), 32'd1);
    do_read(1, A_RX, 32'h0000_00B1, "rx_b1");
    check("intr_fall", 32'(rx_intr[1]), 32'd0);
    do_read(1, A_RX, 32'h0000_00B2, "rx_b2");

    // Ports 0 and 2 push to inbox1 in the same cycle
    do_write(2, A_CTRL, 32'h0000_0100, "ctrl2");
    hsel[0] = 1'b1; haddr[0] = A_TX; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'b010;
    hsel[2] = 1'b1; haddr[2] = A_TX; htrans[2] = 2'b10; hwrite[2] = 1'b1; hsize[2] = 3'b010;
    @(posedge hclk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwrite[0] = 1'b0; hwdata[0] = 32'h0000_00C0;
    hsel[2] = 1'b0; htrans[2] = 2'b00; hwrite[2] = 1'b0; hwdata[2] = 32'h0000_00C2;
    check("arb_rdy0", 32'(hready[0]), 32'd1);
    check("arb_rdy2_stall", 32'(hready[2]), 32'd0);
    @(posedge hclk); #1;
    check("arb_rdy2_go", 32'(hready[2]), 32'd1);
    @(posedge hclk); #1;
    do_read(1, A_RX, 32'h0000_00C0, "rx_c0");
    do_read(1, A_RX, 32'h0000_00C2, "rx_c2");

    // Error responses leave state untouched
    do_err(1, 1'b0, BASE + 32'h10, 3'b010, 2'b10, "err_addr");
    do_read(1, A_ST, 32'h0000_0100, "st1_after_err_addr");
    do_write(0, A_CTRL, 32'h0000_0000, "ctrl0_self");
    do_err(0, 1'b1, A_TX, 3'b010, 2'b10, "err_self_dest");
    do_read(0, A_ST, 32'h0000_0100, "st0_after_self");
    do_write(0, A_CTRL, 32'h0000_0100, "ctrl0_restore");
    do_err(0, 1'b1, A_TX, 3'b011, 2'b10, "err_hsize");
    do_read(1, A_ST, 32'h0000_0100, "st1_after_hsize");
    do_err(0, 1'b1, A_TX, 3'b010, 2'b11, "err_seq");
    do_read(1, A_ST, 32'h0000_0100, "st1_after_seq");

    // Byte write is zero-extended from the low lane
    begin
      logic [31:0] rd; logic [1:0] r1, r2; int w;
      xfer(0, 1'b1, A_TX, 32'h1234_56AB, 3'b000, 2'b10, rd, r1, r2, w);
      check("byte_resp", 32'(r1), 32'd0);
    end
    do_read(1, A_RX, 32'h0000_00AB, "rx_byte");

    // Reset during a STATUS data phase with two words queued
    do_write(0, A_TX, 32'h0000_00E1, "tx_e1");
    do_write(0, A_TX, 32'h0000_00E2, "tx_e2");
    hsel[1] = 1'b1; haddr[1] = A_ST; htrans[1] = 2'b10; hwrite[1] = 1'b0; hsize[1] = 3'b010;
    @(posedge hclk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'b00;
    check("pre_rst_hrdata", hrdata[1], 32'h0000_0002);
    check("pre_rst_intr", 32'(rx_intr[1]), 32'd1);
    hrst_b = 1'b0;
    #1;
    check("async_rst_intr", 32'(rx_intr), 32'h0);
    check("async_rst_hready", 32'(hready), 32'h7);
    check("async_rst_hresp", 32'(hresp), 32'h0);
    check("async_rst_hrdata", hrdata[1], 32'h0);
    #2;
    hrst_b = 1'b1;
    @(posedge hclk); #1;
    do_read(1, A_ST, 32'h0000_0100, "post_rst_status");
    do_read(1, A_CTRL, 32'h0000_0000, "post_rst_ctrl");
    check("post_rst_intr", 32'(rx_intr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
